div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div.sv | 185 ++++++++++++++++++
 tb/tb_div.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU ops.
//
// A restoring shift-subtract divider that works on operand magnitudes and
// produces one quotient bit per cycle. An accepted operation with a nonzero
// divisor spends 32 cycles in CALC, then one cycle in DONE. Divide-by-zero
// skips CALC and goes straight to DONE. Signs are applied to the magnitude
// results when the final iteration completes.
//
// Ports
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start_i     : request a division (sampled only in IDLE)
//   op_i[2:0]   : funct3 -- 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend_i  : rs1 data
//   divisor_i   : rs2 data
//   rd_i        : destination register tag
//   abort_i     : pipeline flush, cancels any operation in progress
//   busy_o      : high in CALC and DONE
//   ready_o     : one-cycle pulse, result_o/rd_o valid
//   result_o    : quotient (DIV/DIVU) or remainder (REM/REMU), held until next DONE
//   rd_o        : tag of the completed operation, held until next DONE
// -----------------------------------------------------------------------------
module div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  rd_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;       // partial remainder
  logic [31:0] quo_q, quo_d;       // dividend bits shift out, quotient bits shift in
  logic [31:0] dvs_q, dvs_d;       // divisor magnitude
  logic        is_rem_q, is_rem_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [4:0]  tag_q, tag_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_q, rd_d;

  // Operand decode for the accept cycle
  logic        accept;
  logic        op_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign accept    = (state_q == ST_IDLE) && start_i && op_i[2] && !abort_i;
  assign op_signed = ~op_i[0];
  assign a_neg     = op_signed & dividend_i[31];
  assign b_neg     = op_signed & divisor_i[31];
  assign a_mag     = a_neg ? (~dividend_i + 32'd1) : dividend_i;
  assign b_mag     = b_neg ? (~divisor_i + 32'd1) : divisor_i;

  // One restoring iteration. The remainder is always below the divisor, so
  // the shifted value fits in 33 bits; bit 33 of the trial difference is the
  // borrow that says the subtraction must be undone.
  logic [33:0] rem_shift;
  logic [33:0] trial;
  logic        fits;
  logic [32:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] q_fin, r_fin;

  assign rem_shift = {rem_q, quo_q[31]};
  assign trial     = rem_shift - {2'b00, dvs_q};
  assign fits      = ~trial[33];
  assign rem_step  = fits ? trial[32:0] : rem_shift[32:0];
  assign quo_step  = {quo_q[30:0], fits};

  // Sign fix-up applied to the values produced by the last iteration
  assign q_fin = q_neg_q ? (~quo_step + 32'd1) : quo_step;
  assign r_fin = r_neg_q ? (~rem_step[31:0] + 32'd1) : rem_step[31:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    tag_d    = tag_q;
    result_d = result_q;
    rd_d     = rd_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tag_d    = rd_i;
          is_rem_d = op_i[1];
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          dvs_d    = b_mag;
          rem_d    = 33'd0;
          quo_d    = a_mag;
          cnt_d    = 6'd0;
          if (divisor_i == 32'd0) begin
            // Divide by zero: quotient all ones, remainder is the raw dividend
            state_d  = ST_DONE;
            result_d = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
            rd_d     = rd_i;
          end else begin
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          if (cnt_q == 6'd31) begin
            state_d  = ST_DONE;
            result_d = is_rem_q ? r_fin : q_fin;
            rd_d     = tag_q;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 33'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      tag_q    <= 5'd0;
      result_q <= 32'd0;
      rd_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  // A flush arriving in the DONE cycle kills the completion pulse.
  assign ready_o  = (state_q == ST_DONE) && !abort_i;
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div -- self-checking bench for div.
//
// Directed cases for the documented corner results, abort and mid-operation
// reset, followed by randomized operations compared against an arithmetic
// reference model.
// -----------------------------------------------------------------------------
module tb_div;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_i;
  logic        abort_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_cmp;
  int n_err;

  logic [31:0] last_res;
  logic [4:0]  last_rd;

  div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_i       (rd_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .rd_o       (rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the RISC-V M-extension definition
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] qq, rr;
    if (b == 32'd0) begin
      qq = 32'hFFFF_FFFF;
      rr = a;
    end else if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qq = q[31:0];
      rr = r[31:0];
    end else begin
      qq = a / b;
      rr = a % b;
    end
    return op[1] ? rr : qq;
  endfunction

  // Entered at #1 after the accept edge (cycle T+1). Waits for ready_o and
  // checks latency, busy, result and tag, then the return to IDLE.
  task automatic wait_done(input int exp_lat, input logic [31:0] exp_res,
                           input logic [4:0] exp_rd, input bit noisy);
    int cyc;
    cyc = 1;
    forever begin
      chk("busy_during_op", busy_o, 1);
      if (ready_o === 1'b1) break;
      if (cyc >= 40) break;
      if (noisy) begin
        // Starts while busy must be ignored and must not recapture operands
        start_i    = 1'b1;
        op_i       = {1'b1, 2'($urandom_range(3))};
        dividend_i = $urandom;
        divisor_i  = $urandom;
        rd_i       = 5'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start_i = 1'b0;
    chk("ready_seen", ready_o, 1);
    chk("latency", cyc, exp_lat);
    chk("result", result_o, exp_res);
    chk("rd_tag", rd_o, exp_rd);
    @(posedge clk);
    #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_ready", ready_o, 0);
    chk("result_hold", result_o, exp_res);
    chk("rd_hold", rd_o, exp_rd);
    last_res = exp_res;
    last_rd  = exp_rd;
  endtask

  // Drives a start at the current time; returns at #1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_i       = rd;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit noisy);
    logic [31:0] exp_res;
    exp_res = ref_div(op, a, b);
    @(negedge clk);
    issue(op, a, b, rd);
    wait_done((b == 32'd0) ? 1 : 33, exp_res, rd, noisy);
    $display("op=%03b a=0x%08h b=0x%08h rd=%0d -> 0x%08h (model 0x%08h)",
             op, a, b, rd, result_o, exp_res);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    last_res   = 32'd0;
    last_rd    = 5'd0;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    op_i       = 3'b000;
    dividend_i = 32'd0;
    divisor_i  = 32'd0;
    rd_i       = 5'd0;
    abort_i    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_rd", rd_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner results
    do_op(3'b101, 32'd100, 32'd7, 5'd5, 0);
    chk("divu_100_7", last_res, 32'h0000_000E);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    chk("div_m7_2", last_res, 32'hFFFF_FFFD);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
    chk("rem_m7_2", last_res, 32'hFFFF_FFFF);
    do_op(3'b101, 32'd5, 32'd0, 5'd8, 0);
    chk("divu_by0", last_res, 32'hFFFF_FFFF);
    do_op(3'b111, 32'd5, 32'd0, 5'd9, 0);
    chk("remu_by0", last_res, 32'h0000_0005);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    chk("div_ovf", last_res, 32'h8000_0000);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    chk("rem_ovf", last_res, 32'h0000_0000);

    // Non-divide funct3 is ignored
    @(negedge clk);
    issue(3'b001, 32'd50, 32'd5, 5'd3);
    chk("nondiv_ignored", busy_o, 0);

    // Abort together with start in IDLE wins
    @(negedge clk);
    abort_i = 1'b1;
    issue(3'b101, 32'd50, 32'd5, 5'd3);
    abort_i = 1'b0;
    chk("abort_start_busy", busy_o, 0);
    chk("abort_start_ready", ready_o, 0);

    // Abort mid-CALC at T+10, restart at T+11, done at T+44
    @(negedge clk);
    issue(3'b101, 32'd1000, 32'd10, 5'd12);
    for (int i = 0; i < 9; i++) begin
      chk("abort_busy", busy_o, 1);
      chk("abort_noready", ready_o, 0);
      @(posedge clk);
      #1;
    end
    chk("abort_busy_t10", busy_o, 1);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    chk("abort_idle_busy", busy_o, 0);
    chk("abort_idle_ready", ready_o, 0);
    chk("abort_result_kept", result_o, last_res);
    chk("abort_rd_kept", rd_o, last_rd);
    issue(3'b111, 32'd12345, 32'd100, 5'd17);
    wait_done(33, ref_div(3'b111, 32'd12345, 32'd100), 5'd17, 0);
    $display("abort/restart: REMU 12345/100 rd=17 -> 0x%08h", result_o);

    // Reset at T+15 mid-CALC
    @(negedge clk);
    issue(3'b101, 32'd1000, 32'd3, 5'd7);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_result", result_o, 0);
    chk("midrst_rd", rd_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3'b101, 32'd9, 32'd3, 5'd4, 0);
    chk("post_rst_divu", last_res, 32'h0000_0003);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      do_op({1'b1, 2'($urandom_range(3))}, pick(), pick(), 5'($urandom),
            bit'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
